master_tile_scheduler: RTL and testbench
========================================

MASTER_TILE_SCHEDULER -- requirements
Module: master_tile_scheduler

Interface
REQ-001 Parameter WIDTH_HEIGHT, 16, systolic array edge length (tile edge).
REQ-002 Parameter ADDR_WIDTH, 16, weight/data memory address width.
REQ-003 Parameter MAX_OUT_ROWS, 128, maximum output matrix rows.
REQ-004 Parameter MAX_OUT_COLS, 128, maximum output matrix columns.
REQ-005 Derived widths: RW = clog2(MAX_OUT_ROWS/WIDTH_HEIGHT); CW = clog2(MAX_OUT_COLS/WIDTH_HEIGHT).
REQ-006 Clock and reset: one clock; reset is synchronous and active-high; ports clk, reset.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  one-cycle job request, honoured only in IDLE.
REQ-010 num_submat_row  in  RW+1  row-tile count, 0..MAX_OUT_ROWS/WIDTH_HEIGHT.
REQ-011 num_submat_col  in  CW+1  column-tile count, 0..MAX_OUT_COLS/WIDTH_HEIGHT.
REQ-012 base_weight, base_data  in  ADDR_WIDTH each  first tile addresses.
REQ-013 weight_stride, data_stride  in  ADDR_WIDTH each  address step between tiles.
REQ-014 mult_done  in  1  one-cycle completion pulse from the multiply controller.
REQ-015 mult_start  out  1  one-cycle tile launch pulse to the multiply controller.
REQ-016 tile_weight_addr, tile_data_addr  out  ADDR_WIDTH each  current tile addresses.
REQ-017 accum_table_submat_row  out  RW; accum_table_submat_col  out  CW  current tile indices.
REQ-018 busy  out  1  high from the cycle after an accepted start until done.
REQ-019 done  out  1  one-cycle job completion pulse.

Function
REQ-020 States: IDLE, ISSUE, WAIT, DONE; all outputs are registered or decoded from state only (Moore).
REQ-021 IDLE + start: latch counts, bases and strides; zero indices; addresses = bases; go to DONE if either count is 0, else ISSUE.
REQ-022 ISSUE: mult_start = 1 for exactly that cycle; unconditional transition to WAIT.
REQ-023 WAIT: hold all address/index outputs stable; on mult_done advance per REQ-024 and go to ISSUE, or to DONE after the last tile.
REQ-024 Order: row index inner, column index outer; row wrap resets row to 0, tile_data_addr to base_data, increments column, adds weight_stride.
REQ-025 Row advance adds data_stride to tile_data_addr; addresses are computed incrementally, without a multiplier, modulo 2^ADDR_WIDTH.
REQ-026 Last tile: row = count_row-1 and col = count_col-1; total mult_start pulses = count_row*count_col.
REQ-027 DONE: done = 1 for one cycle; next state IDLE; indices and addresses retain their final values.
REQ-028 Latency: start accepted at edge t -> mult_start high in cycle t+1; mult_done at edge t -> next mult_start in cycle t+1.
REQ-029 start outside IDLE, and mult_done outside WAIT, are ignored with no state change.
REQ-030 busy = 1 in ISSUE and WAIT, else 0; done and busy are never high together.
REQ-031 Input changes after acceptance have no effect until the next accepted start.

Reset
REQ-032 reset forces IDLE in the same edge, with priority over all other inputs, including mid-job.
REQ-033 Reset values: mult_start, busy, done = 0; addresses = 0; indices = 0; latched config = 0.
REQ-034 First start is honoured in the cycle after reset deasserts.

Structure
REQ-035 Shared package tpu_ctrl_pkg holds the state enum and the tile-count width constants.
REQ-036 One sub-module, submat_counter: 2-D row/column index counter with wrap and last flags, reusable by the data path.

Verification
REQ-037 1x1 job: start -> mult_start in next cycle; mult_done -> done in next cycle; indices 0,0; addresses equal bases.
REQ-038 2x3 job, base_weight=0x100, weight_stride=0x40, base_data=0x800, data_stride=0x10 -> 6 launches with (row,col) (0,0)(1,0)(0,1)(1,1)(0,2)(1,2); data 0x800/0x810; weight 0x100/0x140/0x180.
REQ-039 num_submat_col=0 -> done one cycle after start; zero mult_start pulses.
REQ-040 reset asserted in WAIT of a 4x4 job -> next cycle IDLE, all outputs 0; a later mult_done produces nothing.
REQ-041 start during WAIT and mult_done during ISSUE -> ignored; tile sequence unchanged.
REQ-042 8x8 job with base_data=0xFFF0, data_stride=0x10 -> data address wraps to 0x0000; 64 launches; done once.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the tile scheduler: FSM state encoding and
// tile-count width helpers used by the scheduler and its index counter.
package tpu_ctrl_pkg;

  localparam int DEF_WIDTH_HEIGHT = 16;
  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;

  // Index width for a given output extent; never narrower than one bit.
  function automatic int tile_idx_w(input int max_out, input int tile_edge);
    return ((max_out / tile_edge) > 1) ? $clog2(max_out / tile_edge) : 1;
  endfunction

  localparam int TILE_ROW_W = tile_idx_w(DEF_MAX_OUT_ROWS, DEF_WIDTH_HEIGHT);
  localparam int TILE_COL_W = tile_idx_w(DEF_MAX_OUT_COLS, DEF_WIDTH_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/submat_counter.sv
// 2-D tile index counter: row index runs fastest, column advances on row wrap.
// Exposes the row-wrap flag and a last-tile flag for address bookkeeping.
module submat_counter #(
  parameter int RW = 3,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [RW:0]   count_row,
  input  logic [CW:0]   count_col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          row_last,
  output logic          last
);

  // Compare index+1 against the count so a zero count never underflows.
  assign row_last = (({1'b0, row} + (RW+1)'(1)) == count_row);
  assign last     = row_last && (({1'b0, col} + (CW+1)'(1)) == count_col);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (row_last) begin
        row <= '0;
        col <= col + CW'(1);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

endmodule

// File: rtl/master_tile_scheduler.sv
// Walks the output matrix tile by tile, launching one multiply per tile and
// waiting for its completion; addresses are stepped incrementally.
module master_tile_scheduler
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH_HEIGHT = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MAX_OUT_ROWS = 128,
  parameter int MAX_OUT_COLS = 128,
  localparam int RW = tile_idx_w(MAX_OUT_ROWS, WIDTH_HEIGHT),
  localparam int CW = tile_idx_w(MAX_OUT_COLS, WIDTH_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RW:0]           num_submat_row,
  input  logic [CW:0]           num_submat_col,
  input  logic [ADDR_WIDTH-1:0] base_weight,
  input  logic [ADDR_WIDTH-1:0] base_data,
  input  logic [ADDR_WIDTH-1:0] weight_stride,
  input  logic [ADDR_WIDTH-1:0] data_stride,
  input  logic                  mult_done,
  output logic                  mult_start,
  output logic [ADDR_WIDTH-1:0] tile_weight_addr,
  output logic [ADDR_WIDTH-1:0] tile_data_addr,
  output logic [RW-1:0]         accum_table_submat_row,
  output logic [CW-1:0]         accum_table_submat_col,
  output logic                  busy,
  output logic                  done,
  output sched_state_e          state
);

  sched_state_e          state_next;
  logic [RW:0]           count_row;
  logic [CW:0]           count_col;
  logic [ADDR_WIDTH-1:0] data_base;
  logic [ADDR_WIDTH-1:0] weight_step;
  logic [ADDR_WIDTH-1:0] data_step;
  logic                  accept;
  logic                  step;
  logic                  row_last;
  logic                  last;

  assign accept = (state == ST_IDLE) && start;
  assign step   = (state == ST_WAIT) && mult_done && !last;

  submat_counter #(.RW(RW), .CW(CW)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .advance  (step),
    .count_row(count_row),
    .count_col(count_col),
    .row      (accum_table_submat_row),
    .col      (accum_table_submat_col),
    .row_last (row_last),
    .last     (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) begin
        state_next = ((num_submat_row == '0) || (num_submat_col == '0)) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (mult_done) state_next = last ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      count_row        <= '0;
      count_col        <= '0;
      data_base        <= '0;
      weight_step      <= '0;
      data_step        <= '0;
      tile_weight_addr <= '0;
      tile_data_addr   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count_row        <= num_submat_row;
        count_col        <= num_submat_col;
        data_base        <= base_data;
        weight_step      <= weight_stride;
        data_step        <= data_stride;
        tile_weight_addr <= base_weight;
        tile_data_addr   <= base_data;
      end else if (step) begin
        // Row wrap restarts the data walk and moves to the next weight column.
        if (row_last) begin
          tile_data_addr   <= data_base;
          tile_weight_addr <= tile_weight_addr + weight_step;
        end else begin
          tile_data_addr <= tile_data_addr + data_step;
        end
      end
    end
  end

  assign mult_start = (state == ST_ISSUE);
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_master_tile_scheduler.sv
// Randomized bench for master_tile_scheduler: an event-level reference model
// predicts launches, addresses and completion; literal checks pin key jobs.
module tb_master_tile_scheduler;
  import tpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_submat_row;
  logic [3:0]  num_submat_col;
  logic [15:0] base_weight, base_data, weight_stride, data_stride;
  logic        mult_done;
  logic        mult_start;
  logic [15:0] tile_weight_addr, tile_data_addr;
  logic [2:0]  accum_table_submat_row, accum_table_submat_col;
  logic        busy, done;
  sched_state_e state;

  int vectors = 0;
  int fails   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  master_tile_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .num_submat_row(num_submat_row), .num_submat_col(num_submat_col),
    .base_weight(base_weight), .base_data(base_data),
    .weight_stride(weight_stride), .data_stride(data_stride),
    .mult_done(mult_done), .mult_start(mult_start),
    .tile_weight_addr(tile_weight_addr), .tile_data_addr(tile_data_addr),
    .accum_table_submat_row(accum_table_submat_row),
    .accum_table_submat_col(accum_table_submat_col),
    .busy(busy), .done(done), .state(state)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the remaining tiles of the job as {row, col, weight, data}; the
  // head is the tile currently presented on the outputs.
  logic [37:0] exp_q[$];
  logic        m_busy, m_start, m_done;
  logic [2:0]  m_row, m_col;
  logic [15:0] m_w, m_d;

  always @(posedge clk) begin
    logic [31:0] wa, da;
    if (reset) begin
      exp_q.delete();
      m_busy = 0; m_start = 0; m_done = 0;
      m_row = 0; m_col = 0; m_w = 0; m_d = 0;
    end else if (!m_busy && !m_done && start) begin
      exp_q.delete();
      for (int c = 0; c < int'(num_submat_col); c++)
        for (int r = 0; r < int'(num_submat_row); r++) begin
          wa = 32'(base_weight) + 32'(c) * 32'(weight_stride);
          da = 32'(base_data) + 32'(r) * 32'(data_stride);
          exp_q.push_back({3'(r), 3'(c), wa[15:0], da[15:0]});
        end
      m_row = 0; m_col = 0; m_w = base_weight; m_d = base_data;
      if (exp_q.size() == 0) m_done = 1;
      else begin m_busy = 1; m_start = 1; end
    end else if (m_busy && m_start) begin
      m_start = 0;
    end else if (m_busy && mult_done) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        {m_row, m_col, m_w, m_d} = exp_q[0];
        m_start = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end
  end

  // ---------------- compare + launch log ----------------
  logic [2:0]  log_row[$], log_col[$];
  logic [15:0] log_w[$], log_d[$];
  int          log_done;

  always @(negedge clk) begin
    check("mult_start", mult_start, m_start);
    check("done", done, m_done);
    check("busy", busy, m_busy);
    check("busy_and_done", busy & done, 0);
    check("row", accum_table_submat_row, m_row);
    check("col", accum_table_submat_col, m_col);
    check("weight_addr", tile_weight_addr, m_w);
    check("data_addr", tile_data_addr, m_d);
    if (mult_start === 1'b1) begin
      log_row.push_back(accum_table_submat_row);
      log_col.push_back(accum_table_submat_col);
      log_w.push_back(tile_weight_addr);
      log_d.push_back(tile_data_addr);
    end
    if (done === 1'b1) log_done++;
  end

  // ---------------- driver ----------------
  task automatic clear_log();
    log_row.delete(); log_col.delete(); log_w.delete(); log_d.delete();
    log_done = 0;
  endtask

  task automatic run_job(input int nr, input int nc, input logic [15:0] bw, input logic [15:0] bd,
                         input logic [15:0] ws, input logic [15:0] ds, input bit inject,
                         output int first_lat, output int done_cyc, output int md_cyc);
    int cyc;
    clear_log();
    num_submat_row = 4'(nr); num_submat_col = 4'(nc);
    base_weight = bw; base_data = bd; weight_stride = ws; data_stride = ds;
    start = 1;
    first_lat = -1; done_cyc = -1; md_cyc = -1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    num_submat_row = 4'($urandom_range(0, 8)); num_submat_col = 4'($urandom_range(0, 8));
    base_weight = 16'($urandom); base_data = 16'($urandom);
    weight_stride = 16'($urandom); data_stride = 16'($urandom);
    forever begin
      if (mult_start && first_lat < 0) first_lat = cyc;
      if (done) begin done_cyc = cyc; break; end
      if (cyc > 3000) begin
        vectors++; fails++;
        $display("FAIL job_timeout: got no done after %0d cycles, expected done", cyc);
        break;
      end
      if (mult_start) begin
        if (inject) mult_done = 1'($urandom_range(0, 1));
      end else if (busy) begin
        mult_done = ($urandom_range(0, 2) == 0);
        if (mult_done) md_cyc = cyc;
        if (inject) start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++; mult_done = 0; start = 0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus + literal checks ----------------
  initial begin
    int fl, dc, mc, guard;
    logic [2:0]  r_exp [6];
    logic [2:0]  c_exp [6];
    logic [15:0] w_exp [6];
    logic [15:0] d_exp [6];
    r_exp = '{0, 1, 0, 1, 0, 1};
    c_exp = '{0, 0, 1, 1, 2, 2};
    w_exp = '{16'h100, 16'h100, 16'h140, 16'h140, 16'h180, 16'h180};
    d_exp = '{16'h800, 16'h810, 16'h800, 16'h810, 16'h800, 16'h810};

    reset = 1; start = 0; mult_done = 0;
    num_submat_row = 0; num_submat_col = 0;
    base_weight = 0; base_data = 0; weight_stride = 0; data_stride = 0;
    log_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, ST_IDLE);
    check("reset_busy", busy, 0);
    check("reset_addr", tile_data_addr, 0);
    reset = 0;

    // 1x1 job, started in the first cycle after reset release.
    run_job(1, 1, 16'h1234, 16'h5678, 16'h0010, 16'h0020, 0, fl, dc, mc);
    check("1x1_start_latency", fl, 1);
    check("1x1_done_latency", dc - mc, 1);
    check("1x1_launches", log_w.size(), 1);
    check("1x1_weight", log_w[0], 16'h1234);
    check("1x1_data", log_d[0], 16'h5678);
    check("1x1_index", {log_row[0], log_col[0]}, 0);

    // 2x3 job with a fixed address walk.
    run_job(2, 3, 16'h100, 16'h800, 16'h40, 16'h10, 0, fl, dc, mc);
    check("2x3_launches", log_w.size(), 6);
    if (log_w.size() == 6)
      for (int i = 0; i < 6; i++) begin
        check($sformatf("2x3_row%0d", i), log_row[i], r_exp[i]);
        check($sformatf("2x3_col%0d", i), log_col[i], c_exp[i]);
        check($sformatf("2x3_w%0d", i), log_w[i], w_exp[i]);
        check($sformatf("2x3_d%0d", i), log_d[i], d_exp[i]);
      end

    // Zero column count completes without launching.
    run_job(3, 0, 16'h0, 16'h0, 16'h1, 16'h1, 0, fl, dc, mc);
    check("zero_done_cycle", dc, 1);
    check("zero_launches", log_w.size(), 0);
    check("zero_done_count", log_done, 1);

    // Reset while waiting on a 4x4 job.
    clear_log();
    num_submat_row = 4; num_submat_col = 4;
    base_weight = 16'hAAAA; base_data = 16'h5555; weight_stride = 16'h3; data_stride = 16'h7;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    guard = 0;
    while (!(busy && !mult_start) && guard < 20) begin @(posedge clk); #1; guard++; end
    check("reach_wait", state, ST_WAIT);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("midjob_reset_state", state, ST_IDLE);
    check("midjob_reset_busy", busy, 0);
    check("midjob_reset_waddr", tile_weight_addr, 0);
    clear_log();
    mult_done = 1;
    @(posedge clk); #1;
    mult_done = 0;
    @(posedge clk); #1;
    check("post_reset_launches", log_w.size(), 0);
    check("post_reset_done", log_done, 0);

    // Ignored start/mult_done outside their states.
    run_job(4, 3, 16'h0200, 16'h0300, 16'h0011, 16'h0022, 1, fl, dc, mc);
    check("inject_launches", log_w.size(), 12);
    check("inject_done_count", log_done, 1);

    // 8x8 job with data address wrapping past 0xFFFF.
    run_job(8, 8, 16'h0000, 16'hFFF0, 16'h0100, 16'h0010, 0, fl, dc, mc);
    check("8x8_launches", log_w.size(), 64);
    check("8x8_done_count", log_done, 1);
    if (log_d.size() > 1) check("8x8_wrap_data", log_d[1], 16'h0000);
    if (log_w.size() == 64) check("8x8_last_weight", log_w[63], 16'h0700);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(0, 8), $urandom_range(0, 8), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), fl, dc, mc);
      check($sformatf("rand%0d_done_count", j), log_done, 1);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
